// File: rtl/count_arbiter_if.sv
// count_arbiter_if: requester handshake plus shared counter connection for count_arbiter
interface count_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 8
);
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     ack;
  logic [COUNT_WIDTH-1:0] value;
  logic                   wrap;
  logic                   busy;
  logic                   next;
  logic [COUNT_WIDTH-1:0] count;
  logic                   err;
  modport slave (input req, count, output ack, value, wrap, busy, next, err);
  modport master (output req, count, input ack, value, wrap, busy, next, err);
endinterface

// File: rtl/count_arbiter.sv
// count_arbiter: round-robin sharing of one edge-triggered event counter among requesters
module count_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 8
) (
  input logic            clk_i,
  input logic            rstn_i,
  count_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;
  state_t                 state, state_n;
  logic [IW-1:0]          grant_idx, last, cand, win;
  logic                   found;
  logic [NUM_REQ-1:0]     elig, grant_oh, ack_q;
  logic [COUNT_WIDTH-1:0] expected_q, expected_n, value_q;
  logic                   wrap_q, busy_q, next_q, err_q;
  assign grant_oh   = NUM_REQ'(1) << grant_idx;
  assign expected_n = expected_q + COUNT_WIDTH'(1);
  assign elig       = bus.req & ~(state == SETTLE ? grant_oh : '0) & ~ack_q;
  // round-robin pick starting just after the last winner
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last) + i) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
  // ISSUE always lasts one cycle; IDLE and SETTLE both launch a new pulse when someone wins
  always_comb state_n = state == ISSUE ? SETTLE : (found ? ISSUE : IDLE);
  // state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_n;
  end
  // grant bookkeeping, registered outputs and the counter consistency check
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      grant_idx  <= '0;
      last       <= IW'(NUM_REQ - 1);
      ack_q      <= '0;
      value_q    <= '0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
      next_q     <= 1'b0;
      err_q      <= 1'b0;
      expected_q <= '0;
    end else begin
      if (state != ISSUE && found) begin
        grant_idx <= win;
        last      <= win;
      end
      next_q <= state_n == ISSUE;
      busy_q <= state_n != IDLE;
      ack_q  <= state == SETTLE ? grant_oh : '0;
      wrap_q <= state == SETTLE && bus.count == '0;
      if (state == SETTLE) begin
        value_q    <= bus.count;
        expected_q <= expected_n;
        if (bus.count != expected_n) err_q <= 1'b1;
      end
    end
  end
  assign bus.ack   = ack_q;
  assign bus.value = value_q;
  assign bus.wrap  = wrap_q;
  assign bus.busy  = busy_q;
  assign bus.next  = next_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_count_arbiter.sv
// tb_count_arbiter: randomized and directed checks of count_arbiter against a transaction-level model
module tb_count_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  count_arbiter_if #(.NUM_REQ(N), .COUNT_WIDTH(W)) bus();
  count_arbiter #(.NUM_REQ(N), .COUNT_WIDTH(W)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus.slave));
  // shared counter: increments on each rising edge of next, optionally swallowing the drop_nth pulse
  int           drop_nth = 0;
  int           npulse;
  logic         nprev;
  logic [W-1:0] cnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      nprev  <= 1'b0;
      npulse <= 0;
    end else begin
      nprev <= bus.next;
      if (bus.next && !nprev) begin
        npulse <= npulse + 1;
        if (npulse + 1 != drop_nth) cnt <= cnt + 1'b1;
      end
    end
  end
  assign bus.count = cnt;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: a service granted at edge e pulses next after e, completes at edge e+2
  int           e = 0;
  int           g, g_edge, m_last, pulses;
  bit           has;
  logic [N-1:0] m_ack;
  logic [W-1:0] m_cnt, m_served, m_value;
  bit           m_wrap, m_next, m_busy, m_err;
  logic [N-1:0] persist = '0;
  int           rate = 0;
  task automatic model_reset();
    has = 0; g = 0; g_edge = -100; m_last = N - 1; pulses = 0;
    m_ack = '0; m_cnt = '0; m_served = '0; m_value = '0;
    m_wrap = 0; m_next = 0; m_busy = 0; m_err = 0;
  endtask
  task automatic model_step(input logic [N-1:0] r);
    logic [N-1:0] el;
    bit settle;
    e++;
    settle = has && (e == g_edge + 2);
    el = r & ~m_ack;
    m_ack = '0;
    m_wrap = 0;
    m_next = 0;
    if (settle) begin
      el[g] = 1'b0;
      m_ack[g] = 1'b1;
      pulses++;
      if (pulses != drop_nth) m_cnt = m_cnt + 1'b1;
      m_served = m_served + 1'b1;
      m_value = m_cnt;
      m_wrap = (m_cnt == '0);
      if (m_cnt != m_served) m_err = 1;
      has = 0;
    end
    if (!has)
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (!m_next && el[idx]) begin
          g = idx; m_last = idx; g_edge = e; has = 1; m_next = 1;
        end
      end
    m_busy = has;
  endtask
  // one clock: update model at the edge, compare just after it, then drive requesters on the falling edge
  task automatic cycle();
    @(posedge clk);
    #1;
    if (!rstn) model_reset();
    else model_step(bus.req);
    chk("ack", bus.ack, m_ack);
    chk("next", bus.next, m_next);
    chk("busy", bus.busy, m_busy);
    chk("wrap", bus.wrap, m_wrap);
    chk("err", bus.err, m_err);
    chk("value", bus.value, m_value);
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (m_ack[i]) bus.req[i] = persist[i];
      else if (!bus.req[i] && int'($urandom_range(99)) < rate) bus.req[i] = 1'b1;
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    bus.req = '0; persist = '0; rate = 0; drop_nth = 0;
    cycle();
    cycle();
    rstn = 1'b1;
  endtask
  logic [N-1:0] a_tr [1:10];
  logic [W-1:0] v_tr [1:10];
  logic         n_tr [1:10];
  logic         b_tr [1:10];
  int           order [$];
  logic [W-1:0] vals [$];
  int           wraps;
  initial begin
    bus.req = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    // single request
    bus.req = 4'b0001;
    cycle(); chk("t1_next_c1", bus.next, 1);
    cycle(); chk("t1_next_c2", bus.next, 0);
    cycle(); chk("t1_ack_c3", bus.ack, 4'b0001);
    chk("t1_value", bus.value, 1); chk("t1_wrap", bus.wrap, 0); chk("t1_err", bus.err, 0);
    repeat (3) cycle();
    // all four requesters at once
    do_reset();
    bus.req = 4'b1111;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      a_tr[c] = bus.ack; v_tr[c] = bus.value; n_tr[c] = bus.next; b_tr[c] = bus.busy;
    end
    chk("t2_next_c1", n_tr[1], 1); chk("t2_next_c2", n_tr[2], 0);
    chk("t2_next_c7", n_tr[7], 1);
    chk("t2_ack_c3", a_tr[3], 4'b0001); chk("t2_ack_c5", a_tr[5], 4'b0010);
    chk("t2_ack_c7", a_tr[7], 4'b0100); chk("t2_ack_c9", a_tr[9], 4'b1000);
    chk("t2_val_c5", v_tr[5], 2); chk("t2_val_c9", v_tr[9], 4);
    chk("t2_busy_c8", b_tr[8], 1); chk("t2_busy_c9", b_tr[9], 0);
    // two permanent requesters alternate
    do_reset();
    persist = 4'b0101; bus.req = 4'b0101;
    order.delete();
    repeat (24) begin
      cycle();
      for (int i = 0; i < N; i++) if (bus.ack[i]) order.push_back(i);
    end
    chk("t3_count", order.size() >= 8, 1);
    for (int k = 0; k < 8 && k < order.size(); k++) chk("t3_order", order[k], (k % 2 == 0) ? 0 : 2);
    // continuous load across the counter wrap
    do_reset();
    persist = 4'b1111; bus.req = 4'b1111; wraps = 0;
    repeat (600) begin
      cycle();
      if (bus.wrap) begin
        wraps++;
        chk("t4_wrap_value", bus.value, 0);
      end
    end
    chk("t4_wraps", wraps, 1);
    chk("t4_err", bus.err, 0);
    // counter swallows the third pulse
    do_reset();
    drop_nth = 3; persist = 4'b0001; bus.req = 4'b0001;
    vals.delete();
    repeat (20) begin
      cycle();
      if (bus.ack != '0) vals.push_back(bus.value);
    end
    chk("t5_acks", vals.size() >= 3, 1);
    if (vals.size() >= 3) chk("t5_third_value", vals[2], 2);
    chk("t5_err", bus.err, 1);
    rate = 30; persist = 4'($urandom);
    repeat (100) cycle();
    chk("t5_err_sticky", bus.err, 1);
    do_reset();
    chk("t5_err_cleared", bus.err, 0);
    // reset during SETTLE drops the grant
    bus.req = 4'b0001;
    cycle();
    cycle();
    chk("t6_busy_settle", bus.busy, 1);
    rstn = 1'b0;
    #1;
    chk("t6_next_rst", bus.next, 0); chk("t6_busy_rst", bus.busy, 0); chk("t6_ack_rst", bus.ack, 0);
    cycle();
    rstn = 1'b1;
    cycle(); chk("t6_ack_c1", bus.ack, 0);
    cycle(); chk("t6_ack_c2", bus.ack, 0);
    cycle(); chk("t6_ack_c3", bus.ack, 4'b0001); chk("t6_value", bus.value, 1);
    // random traffic
    do_reset();
    rate = 20;
    for (int p = 0; p < 6; p++) begin
      persist = 4'($urandom);
      repeat (500) cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
